// File: rtl/nn_sample_sequencer_if.sv
// Feature-beat, Neural_net indicator and classification-result signals shared by
// nn_sample_sequencer (slave) and the surrounding source/network/consumer (master).
interface nn_sample_sequencer_if #(
   parameter int N_FEAT = 60,
   parameter int FEAT_W = 16
);
   logic                     in_valid;
   logic [FEAT_W-1:0]        in_data;
   logic                     in_last;
   logic                     in_ready;
   logic [N_FEAT*FEAT_W-1:0] uzorak;
   logic                     indikator_1;
   logic                     indikator_2;
   logic                     res_valid;
   logic                     res_ready;
   logic                     res_mina;
   logic                     res_stijena;
   logic                     res_nejasno;
   logic                     err_len;
   logic                     busy;

   modport master (
      output in_valid, in_data, in_last, indikator_1, indikator_2, res_ready,
      input  in_ready, uzorak, res_valid, res_mina, res_stijena, res_nejasno, err_len, busy
   );

   modport slave (
      input  in_valid, in_data, in_last, indikator_1, indikator_2, res_ready,
      output in_ready, uzorak, res_valid, res_mina, res_stijena, res_nejasno, err_len, busy
   );
endinterface

// File: rtl/nn_sample_sequencer.sv
// Streams N_FEAT feature beats into a packed sample, lets Neural_net settle, then
// captures its indicators as a handshaked result. Define NN_RESULT_CNT_EN for result counters.
module nn_sample_sequencer #(
   parameter int N_FEAT     = 60,
   parameter int FEAT_W     = 16,
   parameter int SETTLE_CYC = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   nn_sample_sequencer_if.slave bus
`ifdef NN_RESULT_CNT_EN
   ,
   output logic [15:0]          cnt_uzoraka,
   output logic [15:0]          cnt_mina
`endif
);
   localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam int UZ_W  = N_FEAT * FEAT_W;
   localparam int POS_W = (UZ_W > 1) ? $clog2(UZ_W) : 1;

   typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_RESULT} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] beat_idx;
   logic [7:0]       settle_cnt;
   logic [POS_W-1:0] slot_lsb;
   logic             beat_acc;
   logic             last_idx;
   logic             good_end;
   logic             len_err;
   logic             settle_done;

   assign beat_acc    = bus.in_valid && bus.in_ready;
   assign last_idx    = (beat_idx == IDX_W'(N_FEAT - 1));
   assign good_end    = beat_acc && last_idx && bus.in_last;
   // A length error is a last marker on the wrong beat, or a missing one on the final beat.
   assign len_err     = beat_acc && (last_idx != bus.in_last);
   assign settle_done = (state == ST_SETTLE) && (settle_cnt == 8'd1);
   // Feature k lands at LSB offset (N_FEAT-1-k)*FEAT_W, so feature 0 sits in the MSBs.
   assign slot_lsb    = POS_W'((N_FEAT - 1 - int'(beat_idx)) * FEAT_W);

   // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_LOAD;
      else     state <= state_nxt;
   end

   // NOTE: the default assignment up front keeps this combinational block free of inferred latches.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOAD:   if (good_end)      state_nxt = ST_SETTLE;
         ST_SETTLE: if (settle_done)   state_nxt = ST_RESULT;
         ST_RESULT: if (bus.res_ready) state_nxt = ST_LOAD;
         default:                      state_nxt = ST_LOAD;
      endcase
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.busy      = 1'b0;
      bus.res_valid = 1'b0;
      case (state)
         ST_LOAD:   bus.in_ready = 1'b1;
         ST_SETTLE: bus.busy     = 1'b1;
         ST_RESULT: begin
            bus.busy      = 1'b1;
            bus.res_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_idx        <= '0;
         settle_cnt      <= '0;
         // NOTE: the sample register is cleared on reset so Neural_net sees all-zero features afterwards.
         bus.uzorak      <= '0;
         bus.res_mina    <= 1'b0;
         bus.res_stijena <= 1'b0;
         bus.res_nejasno <= 1'b0;
         bus.err_len     <= 1'b0;
      end else begin
         bus.err_len <= len_err;
         if (beat_acc) begin
            bus.uzorak[slot_lsb +: FEAT_W] <= bus.in_data;
            beat_idx <= (last_idx || bus.in_last) ? '0 : beat_idx + IDX_W'(1);
         end
         if (good_end)                settle_cnt <= 8'(SETTLE_CYC);
         else if (state == ST_SETTLE) settle_cnt <= settle_cnt - 8'd1;
         if (settle_done) begin
            bus.res_mina    <= bus.indikator_1;
            bus.res_stijena <= bus.indikator_2;
            bus.res_nejasno <= (bus.indikator_1 == bus.indikator_2);
         end
      end
   end

`ifdef NN_RESULT_CNT_EN
   logic res_hs;
   assign res_hs = (state == ST_RESULT) && bus.res_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_uzoraka <= '0;
         cnt_mina    <= '0;
      end else if (res_hs) begin
         if (cnt_uzoraka != 16'hFFFF) cnt_uzoraka <= cnt_uzoraka + 16'd1;
         if (bus.res_mina && !bus.res_stijena && (cnt_mina != 16'hFFFF))
            cnt_mina <= cnt_mina + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_nn_sample_sequencer.sv
// Randomized scoreboard bench for nn_sample_sequencer: a driver pushes expected events
// computed from a feature-array model, and a negedge monitor pops and compares them.
module tb_nn_sample_sequencer;
   localparam int N_FEAT     = 60;
   localparam int FEAT_W     = 16;
   localparam int SETTLE_CYC = 4;
   localparam int UZ_W       = N_FEAT * FEAT_W;
   localparam int CLK_HALF   = 5;

   typedef enum {EV_RESULT, EV_ERR, EV_ABORT} ev_kind_e;
   typedef struct {
      ev_kind_e         kind;
      int               acc;
      logic [2:0]       res;
      logic [UZ_W-1:0]  uz;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   nn_sample_sequencer_if #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W)) bus ();

`ifdef NN_RESULT_CNT_EN
   logic [15:0] cnt_uzoraka;
   logic [15:0] cnt_mina;
`endif

   nn_sample_sequencer #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus)
`ifdef NN_RESULT_CNT_EN
      ,
      .cnt_uzoraka (cnt_uzoraka),
      .cnt_mina    (cnt_mina)
`endif
   );

   always #CLK_HALF clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ev_t               sb[$];
   logic [FEAT_W-1:0] model_feat [N_FEAT];
   int                exp_cnt_uz   = 0;
   int                exp_cnt_mina = 0;
   bit                net_hold = 1'b0;
   bit                net_i1   = 1'b0;
   bit                net_i2   = 1'b0;
   int                net_cyc  = -1;
   int                rr_hold  = 0;

   task automatic check(input string name, input logic [UZ_W-1:0] act, input logic [UZ_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got an unexpected event or timeout, expected none", name);
   endtask

   function automatic logic [UZ_W-1:0] pack_model();
      logic [UZ_W-1:0] v = '0;
      for (int i = 0; i < N_FEAT; i++) v = (v << FEAT_W) | UZ_W'(model_feat[i]);
      return v;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < N_FEAT; i++) model_feat[i] = '0;
   endtask

   // Neural_net stand-in: noise on the indicators except in the cycle the result must be sampled.
   always @(posedge clk) begin
      #2;
      if (net_hold || cyc == net_cyc) begin
         bus.indikator_1 = net_i1;
         bus.indikator_2 = net_i2;
      end else begin
         bus.indikator_1 = 1'($urandom_range(0, 1));
         bus.indikator_2 = 1'($urandom_range(0, 1));
      end
   end

   always @(posedge clk) begin
      #1;
      if (rr_hold > 0) begin
         bus.res_ready = 1'b0;
         rr_hold--;
      end else begin
         bus.res_ready = ($urandom_range(0, 2) == 0);
      end
   end

   logic            prev_busy  = 1'b0;
   logic            prev_valid = 1'b0;
   logic            prev_hs    = 1'b0;
   logic [UZ_W-1:0] prev_uz    = '0;
   logic [2:0]      prev_res   = '0;

   always @(negedge clk) begin
      if (rst) begin
         if (sb.size() > 0 && sb[0].kind == EV_ABORT) void'(sb.pop_front());
         exp_cnt_uz   = 0;
         exp_cnt_mina = 0;
      end else begin
`ifdef NN_RESULT_CNT_EN
         check("cnt_uzoraka", cnt_uzoraka, exp_cnt_uz);
         check("cnt_mina", cnt_mina, exp_cnt_mina);
`endif
         check("in_ready_vs_busy", bus.in_ready, !bus.busy);
         if (prev_hs) check("release_after_handshake", {bus.res_valid, bus.busy}, 2'b00);
         if (prev_busy && bus.busy) check("uzorak_stable", bus.uzorak, prev_uz);
         if (prev_valid && bus.res_valid)
            check("result_stable", {bus.res_mina, bus.res_stijena, bus.res_nejasno}, prev_res);
         if (bus.busy && !prev_busy) begin
            if (sb.size() == 0 || sb[0].kind == EV_ERR) fail("unexpected_busy");
            else begin
               check("busy_rise_cycle", cyc, sb[0].acc + 1);
               check("uzorak_sample", bus.uzorak, sb[0].uz);
            end
         end
         if (bus.res_valid && !prev_valid) begin
            if (sb.size() == 0 || sb[0].kind != EV_RESULT) fail("unexpected_res_valid");
            else begin
               check("res_valid_rise_cycle", cyc, sb[0].acc + SETTLE_CYC + 1);
               check("result_value", {bus.res_mina, bus.res_stijena, bus.res_nejasno}, sb[0].res);
            end
         end
         if (bus.err_len) begin
            if (sb.size() == 0 || sb[0].kind != EV_ERR) fail("unexpected_err_len");
            else begin
               check("err_len_cycle", cyc, sb[0].acc + 1);
               void'(sb.pop_front());
            end
         end
         if (bus.res_valid && bus.res_ready && sb.size() > 0 && sb[0].kind == EV_RESULT) begin
            ev_t ev;
            ev = sb.pop_front();
            if (exp_cnt_uz < 16'hFFFF) exp_cnt_uz++;
            if (ev.res[2] && !ev.res[1] && exp_cnt_mina < 16'hFFFF) exp_cnt_mina++;
         end
      end
      prev_busy  = bus.busy;
      prev_valid = bus.res_valid;
      prev_hs    = !rst && bus.res_valid && bus.res_ready;
      prev_uz    = bus.uzorak;
      prev_res   = {bus.res_mina, bus.res_stijena, bus.res_nejasno};
   end

   task automatic wait_accept(output int acc);
      int  n = 0;
      bit  done = 1'b0;
      acc = -1;
      while (!done) begin
         @(negedge clk);
         if (!rst && bus.in_ready === 1'b1) begin
            acc  = cyc;
            done = 1'b1;
         end else if (++n > 500) begin
            fail("beat_accept_timeout");
            done = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_sample(input int n_beats, input bit with_last, input bit gaps,
                              input bit directed, input bit abort);
      int                acc = -1;
      ev_t               ev;
      logic [FEAT_W-1:0] d;
      for (int k = 0; k < n_beats; k++) begin
         if (gaps && $urandom_range(0, 4) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         d            = directed ? FEAT_W'(k + 1) : FEAT_W'($urandom);
         bus.in_valid = 1'b1;
         bus.in_data  = d;
         bus.in_last  = with_last && (k == n_beats - 1);
         wait_accept(acc);
         if (acc >= 0) model_feat[k] = d;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (n_beats == N_FEAT && with_last) begin
         ev.kind  = abort ? EV_ABORT : EV_RESULT;
         net_i1   = directed ? 1'b1 : 1'($urandom_range(0, 1));
         net_i2   = directed ? 1'b0 : 1'($urandom_range(0, 1));
         net_hold = directed;
         net_cyc  = acc + SETTLE_CYC;
         ev.res   = {net_i1, net_i2, net_i1 == net_i2};
      end else if (with_last || n_beats == N_FEAT) begin
         ev.kind = EV_ERR;
         ev.res  = '0;
      end else begin
         return;
      end
      ev.acc = acc;
      ev.uz  = pack_model();
      sb.push_back(ev);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_in_ready"}, bus.in_ready, 1'b1);
      check({tag, "_busy"}, bus.busy, 1'b0);
      check({tag, "_res_valid"}, bus.res_valid, 1'b0);
      check({tag, "_results"}, {bus.res_mina, bus.res_stijena, bus.res_nejasno}, 3'b000);
      check({tag, "_err_len"}, bus.err_len, 1'b0);
      check({tag, "_uzorak"}, bus.uzorak, '0);
`ifdef NN_RESULT_CNT_EN
      check({tag, "_counters"}, {cnt_uzoraka, cnt_mina}, 32'd0);
`endif
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_model();
      @(negedge clk);
      check_reset_state(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #(CLK_HALF * 2 * 60000);
      $display("FAIL watchdog: got no summary before the time limit, expected a finished run");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_valid    = 1'b0;
      bus.in_data     = '0;
      bus.in_last     = 1'b0;
      bus.res_ready   = 1'b0;
      bus.indikator_1 = 1'b0;
      bus.indikator_2 = 1'b0;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("por");
      @(posedge clk);
      #1;

      // Ramp sample with a fixed mine verdict; the consumer stalls well past the result.
      send_sample(N_FEAT, 1'b1, 1'b0, 1'b1, 1'b0);
      rr_hold = SETTLE_CYC + 12;
      @(negedge clk);
      check("uzorak_first_slot", bus.uzorak[UZ_W-1 -: FEAT_W], 16'h0001);
      check("uzorak_last_slot", bus.uzorak[FEAT_W-1:0], 16'h003C);
      check("busy_after_last_beat", bus.busy, 1'b1);
      @(posedge clk);
      #1;

      send_sample(30, 1'b1, 1'b0, 1'b0, 1'b0);
      send_sample(N_FEAT, 1'b1, 1'b0, 1'b0, 1'b0);
      send_sample(N_FEAT, 1'b0, 1'b0, 1'b0, 1'b0);
      send_sample(1, 1'b1, 1'b0, 1'b0, 1'b0);
      send_sample(1, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int s = 0; s < 30; s++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 7)      send_sample(N_FEAT, 1'b1, 1'b1, 1'b0, 1'b0);
         else if (r < 9) send_sample($urandom_range(1, N_FEAT - 1), 1'b1, 1'b1, 1'b0, 1'b0);
         else            send_sample(N_FEAT, 1'b0, 1'b1, 1'b0, 1'b0);
      end

      // Reset in the second SETTLE cycle drops the pending result.
      send_sample(N_FEAT, 1'b1, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      pulse_reset("abort_settle");

      send_sample(20, 1'b0, 1'b0, 1'b0, 1'b0);
      pulse_reset("abort_load");

      for (int s = 0; s < 4; s++) send_sample(N_FEAT, 1'b1, 1'b1, 1'b0, 1'b0);

      for (int t = 0; t < 2000 && sb.size() > 0; t++) @(posedge clk);
      if (sb.size() != 0) fail("scoreboard_drain");
      @(negedge clk);
`ifdef NN_RESULT_CNT_EN
      check("cnt_uzoraka_final", cnt_uzoraka, exp_cnt_uz);
      check("cnt_mina_final", cnt_mina, exp_cnt_mina);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/nn_sample_sequencer.md
NN_SAMPLE_SEQUENCER -- requirements
Module: nn_sample_sequencer

Interface
REQ-001 Parameter N_FEAT, default 60, number of features per sample.
REQ-002 Parameter FEAT_W, default 16, feature width in bits.
REQ-003 Parameter SETTLE_CYC, default 4, hold cycles after load before sampling the network outputs; legal range 1..255.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  feature beat valid.
REQ-007 in_data  in  FEAT_W  feature value.
REQ-008 in_last  in  1  marks the final beat of a sample.
REQ-009 in_ready  out  1  sequencer accepts a beat this cycle.
REQ-010 uzorak  out  N_FEAT*FEAT_W  packed sample driven into Neural_net.
REQ-011 indikator_1  in  1  Neural_net mine indicator.
REQ-012 indikator_2  in  1  Neural_net rock indicator.
REQ-013 res_valid  out  1  classification result available.
REQ-014 res_ready  in  1  consumer accepts the result.
REQ-015 res_mina  out  1  captured indikator_1.
REQ-016 res_stijena  out  1  captured indikator_2.
REQ-017 res_nejasno  out  1  high when the captured indicators are equal (ambiguous).
REQ-018 err_len  out  1  one-cycle pulse on a sample-length error.
REQ-019 busy  out  1  high in SETTLE or RESULT.

Function
REQ-020 FSM states: LOAD, SETTLE, RESULT.
REQ-021 LOAD: in_ready=1. A beat is accepted when in_valid=1 and in_ready=1.
REQ-022 Accepted beat k (0-based) is written to uzorak[(N_FEAT-k)*FEAT_W-1 -: FEAT_W]: feature 0 occupies the MSBs, feature N_FEAT-1 the LSBs. Other slots are unchanged.
REQ-023 Beat k=N_FEAT-1 accepted with in_last=1: go to SETTLE, load the settle counter with SETTLE_CYC, and reset the beat index to 0.
REQ-024 in_last=1 on beat k<N_FEAT-1, or in_last=0 on beat k=N_FEAT-1: the beat is written, err_len pulses for one cycle, the beat index returns to 0, and the state stays LOAD. The sample is discarded and no result is produced.
REQ-025 SETTLE: in_ready=0 and uzorak is held stable. The counter decrements once per cycle.
REQ-026 When the SETTLE counter reads 1, the sequencer samples indikator_1/2 into res_mina/res_stijena, computes res_nejasno, and enters RESULT on the next edge. Total SETTLE duration is exactly SETTLE_CYC cycles.
REQ-027 RESULT: res_valid=1 and in_ready=0. Result outputs are stable until the handshake.
REQ-028 res_valid=1 and res_ready=1 in the same cycle: the result is consumed and the state returns to LOAD next cycle; res_valid=0 from then.
REQ-029 res_ready=1 outside RESULT has no effect; in_valid outside LOAD is ignored, with no beat consumed.
REQ-030 uzorak keeps its last contents across samples until overwritten slot by slot.
REQ-031 Throughput: one sample per N_FEAT+SETTLE_CYC+1 cycles minimum, with zero bubbles on input beats.

Reset
REQ-032 On rst=1 at a clock edge: state LOAD, beat index 0, settle counter 0, uzorak all zeros, res_valid/res_mina/res_stijena/res_nejasno/err_len 0, busy 0, in_ready 1 on the next cycle.
REQ-033 rst mid-load, mid-SETTLE or in RESULT aborts the operation. The partial sample or pending result is lost and no err_len pulse is generated.

Configuration
REQ-034 Macro NN_RESULT_CNT_EN, when defined, adds outputs cnt_uzoraka[15:0] and cnt_mina[15:0].
REQ-035 cnt_uzoraka increments on each result handshake. cnt_mina increments on each handshake with res_mina=1 and res_stijena=0.
REQ-036 Both counters saturate at 16'hFFFF and are zeroed by rst.
REQ-037 With NN_RESULT_CNT_EN undefined, these ports and their logic are absent and all other behaviour is identical.

Verification
REQ-038 Sixty beats with in_data=k+1 and in_last on beat 59 -> uzorak[959:944]=16'h0001, uzorak[15:0]=16'h003C, busy rises the cycle after beat 59.
REQ-039 Defaults, with the network model holding indikator_1=1 and indikator_2=0 -> res_valid rises exactly 5 cycles after beat 59 is accepted, with res_mina=1, res_stijena=0, res_nejasno=0.
REQ-040 in_last on beat 29 -> err_len pulses for 1 cycle, no res_valid, and the next 60-beat sample classifies normally.
REQ-041 res_ready held low for 10 cycles in RESULT -> res_valid is held and outputs are stable; in_valid=1 is not accepted until the cycle after the handshake.
REQ-042 rst asserted in cycle 2 of SETTLE -> next cycle all outputs match REQ-032 and res_valid never rises.
REQ-043 With NN_RESULT_CNT_EN defined, 3 samples (mine, rock, mine) -> cnt_uzoraka=3 and cnt_mina=2.
